// File: rtl/tx_uart_fifo.sv
// Byte FIFO with an output sequencer feeding a transmit UART.
// Bytes written from the CPU side are queued. The sequencer keeps one byte
// on tx_data/tx_valid until the UART's completion pulse, then loads the next.
module tx_uart_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int LOW_WATERMARK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  input  logic                  flush,
  input  logic                  clr_overflow,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  busy,
  output logic                  irq_low,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LOW_LEVEL  = (DEPTH_LOG2+1)'(LOW_WATERMARK);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic [7:0]            data_q;
  logic                  ovf_q;
  logic                  push, pop, drop;

  // Status flags come from registers only, never from wr_valid or tx_ready.
  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LEVEL);
  assign wr_ready = !full;
  assign tx_valid = (state == SEND);
  assign tx_data  = data_q;
  assign busy     = tx_valid | !empty;
  assign irq_low  = (level_q <= LOW_LEVEL);
  assign level    = level_q;
  assign overflow = ovf_q;

  // A full FIFO never accepts a write, even if a pop frees a slot this cycle.
  assign push = wr_valid & !full & !flush;
  assign drop = wr_valid & full & !flush;

  // Sequencer next state and pop decision.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (!empty && !flush) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, level, held output byte and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (flush) begin
        // A flush empties the queue but leaves the byte already on tx_data.
        wptr    <= '0;
        rptr    <= '0;
        level_q <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        unique case ({push, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
      if (pop) data_q <= mem[rptr];
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_overflow) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: doc/tx_uart_fifo.md
Name: tx_uart_fifo

Overview:
- Byte FIFO plus output sequencer that sits directly upstream of the transmit UART.
- Accepts bytes from the CPU/MMIO write path and buffers them.
- Drives the UART's valid/data inputs and holds them until the UART's one-cycle completion pulse, then presents the next byte.
- Lets software queue DEPTH bytes without polling between bytes.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries, minimum 1.
- LOW_WATERMARK, 4: irq_low asserts while level <= LOW_WATERMARK; range 0..2**DEPTH_LOG2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write strobe; byte on wr_data is pushed this cycle if wr_ready.
- wr_data  input  8  byte to enqueue.
- wr_ready  output  1  = !full.
- flush  input  1  one-cycle request to discard all queued bytes.
- clr_overflow  input  1  clears the overflow flag.
- tx_valid  output  1  to the UART valid input; byte available.
- tx_data  output  8  to the UART tx_data input; stable while tx_valid=1.
- tx_ready  input  1  from the UART ready output; one-cycle pulse when the current frame, including stop time, completes.
- level  output  DEPTH_LOG2+1  entries stored in the FIFO; excludes the byte held on tx_data.
- empty  output  1  level == 0.
- full  output  1  level == 2**DEPTH_LOG2.
- busy  output  1  tx_valid | !empty.
- irq_low  output  1  level <= LOW_WATERMARK.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0, level=0, empty=1, full=0, wr_ready=1, busy=0, overflow=0.
  - irq_low=1; state=IDLE; read/write pointers=0.
- Storage:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap naturally.
  - Separate registered level counter.
  - empty, full, wr_ready, busy and irq_low are combinational from registers only; no path from wr_valid or tx_ready.
- Push: wr_valid & !full & !flush writes mem[wptr], wptr+1, level+1.
- Full write: wr_valid & full drops the byte and sets overflow. Nothing else changes.
- overflow: cleared by clr_overflow. If set and clear coincide, set wins.
- Output sequencer, two states:
  - IDLE: tx_valid=0. If !empty & !flush: tx_data<=mem[rptr], rptr+1, level-1, tx_valid<=1, go SEND.
  - SEND: tx_valid and tx_data held constant. tx_ready=0 keeps the state.
  - SEND, tx_ready=1 and !empty and !flush: load next byte into tx_data, pop, stay SEND. tx_valid stays 1, giving back-to-back frames.
  - SEND, tx_ready=1 and (empty or flush): tx_valid<=0, go IDLE.
- tx_ready in IDLE is ignored.
- Latency: byte written at edge N into an empty FIFO in IDLE gives tx_valid=1 after edge N+1, and level returns to 0 after edge N+1.
- UART interlock: the UART ignores valid during its ready cycle, so loading the new byte on that edge is safe. The new frame starts one cycle later.
- Simultaneous push and pop: both occur, level unchanged. When full, a pop in the same cycle does NOT make room for that cycle's write; the write is dropped and overflow is set.
- Flush:
  - Sets rptr=wptr=0, level=0. Any same-cycle write is dropped without setting overflow. Any same-cycle pop is suppressed.
  - A byte already on tx_data is NOT aborted, because the UART cannot cancel a frame. tx_valid stays 1 until tx_ready, then IDLE.
- Reset mid-frame: outputs return to reset values next edge. The downstream UART shares the same reset domain, so no frame is left half-acknowledged.
- Width rules: level is DEPTH_LOG2+1 bits and never exceeds 2**DEPTH_LOG2. Pointer arithmetic is modulo 2**DEPTH_LOG2.

Test Plan:
- Reset, then idle 10 cycles -> tx_valid=0, empty=1, level=0, irq_low=1, busy=0.
- Single write 0x41 into empty FIFO at edge N -> tx_valid=1, tx_data=0x41 after edge N+1, level=0. tx_ready pulse 20 cycles later -> tx_valid=0 next edge, busy=0.
- Write 0x10..0x1F (16 bytes, DEPTH_LOG2=4) with UART model ready pulse every 30 cycles -> tx_data sequence 0x10..0x1F in order. tx_valid never drops between bytes. level peaks at 15. irq_low deasserts at level 5 and reasserts at level 4.
- Fill to full while the UART stalls, then write 0xEE -> wr_ready=0, 0xEE absent from the output stream, overflow=1. clr_overflow -> overflow=0.
- Full FIFO, write and tx_ready in the same cycle -> pop occurs, write dropped, overflow=1, level=15.
- Queue 5 bytes with byte 0 on tx_data, pulse flush -> level=0, tx_data unchanged and held until tx_ready, then tx_valid=0. A write in the flush cycle does not appear and overflow stays 0.
